// File: rtl/blowfish128_round_ctrl.sv
// Blowfish-128 Feistel round sequencer: walks ROUNDS rounds over a 128-bit block,
// fetching subkeys from the P-array and driving a shared multi-cycle F-function.
module blowfish128_round_ctrl #(
  parameter int ROUNDS    = 16,
  parameter int PAW       = $clog2(ROUNDS + 2),
  parameter int F_TIMEOUT = 16
) (
  input  logic           Clk,
  input  logic           RstN,
  input  logic           InValid,
  output logic           InReady,
  input  logic           Decrypt,
  input  logic [127:0]   DataIn,
  input  logic           Abort,
  output logic [PAW-1:0] PAddr,
  input  logic [63:0]    PData,
  output logic           FEnable,
  output logic [63:0]    FX,
  input  logic [63:0]    FY,
  input  logic           FValid,
  output logic           OutValid,
  input  logic           OutReady,
  output logic [127:0]   DataOut,
  output logic           Busy,
  output logic           Err
);

  localparam int TW = $clog2(F_TIMEOUT + 1);
  localparam logic [PAW-1:0] LAST_ROUND = PAW'(ROUNDS - 1);
  localparam logic [TW-1:0]  T_MAX      = TW'(F_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_P, S_XOR_L, S_F_RUN, S_FIN_RD1, S_FIN_RD2, S_FIN_X, S_DONE
  } state_t;

  state_t          r_state, w_next;
  logic [63:0]     r_l, r_r;
  logic [PAW-1:0]  r_round;
  logic [TW-1:0]   r_tcnt;
  logic            r_dec;
  logic            r_err;

  logic            w_abort;
  logic            w_lastRound;
  logic            w_timeout;
  logic [63:0]     w_rn;
  logic [PAW-1:0]  w_idx;

  assign w_abort     = Abort && (r_state != S_IDLE);
  assign w_lastRound = (r_round == LAST_ROUND);
  assign w_timeout   = (r_tcnt == T_MAX);
  assign w_rn        = r_r ^ FY;
  // Decryption walks the P-array backwards from the top.
  assign w_idx       = r_dec ? (PAW'(ROUNDS + 1) - r_round) : r_round;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    InReady  = 1'b0;
    FEnable  = 1'b0;
    FX       = 64'h0;
    PAddr    = '0;
    OutValid = 1'b0;
    DataOut  = 128'h0;
    Busy     = (r_state != S_IDLE);
    Err      = r_err;
    case (r_state)
      S_IDLE: begin
        InReady = 1'b1;
        if (InValid) w_next = S_RD_P;
      end
      S_RD_P: begin
        PAddr  = w_idx;
        w_next = S_XOR_L;
      end
      S_XOR_L: w_next = S_F_RUN;
      S_F_RUN: begin
        FEnable = 1'b1;
        FX      = r_l;
        if (FValid)         w_next = w_lastRound ? S_FIN_RD1 : S_RD_P;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_FIN_RD1: begin
        PAddr  = r_dec ? PAW'(1) : PAW'(ROUNDS);
        w_next = S_FIN_RD2;
      end
      S_FIN_RD2: begin
        PAddr  = r_dec ? PAW'(0) : PAW'(ROUNDS + 1);
        w_next = S_FIN_X;
      end
      S_FIN_X: w_next = S_DONE;
      S_DONE: begin
        OutValid = 1'b1;
        DataOut  = {r_l, r_r};
        if (OutReady) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  // Datapath: abort freezes everything so a cancelled block leaves no side effects.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_l     <= 64'h0;
      r_r     <= 64'h0;
      r_round <= '0;
      r_tcnt  <= '0;
      r_dec   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (!w_abort) begin
        case (r_state)
          S_IDLE: begin
            if (InValid) begin
              r_l     <= DataIn[127:64];
              r_r     <= DataIn[63:0];
              r_dec   <= Decrypt;
              r_round <= '0;
            end
          end
          S_XOR_L: begin
            r_l    <= r_l ^ PData;
            r_tcnt <= '0;
          end
          S_F_RUN: begin
            if (FValid) begin
              if (w_lastRound) begin
                r_r <= w_rn;
              end else begin
                r_l     <= w_rn;
                r_r     <= r_l;
                r_round <= r_round + PAW'(1);
              end
            end else if (w_timeout) begin
              r_err <= 1'b1;
            end else begin
              r_tcnt <= r_tcnt + TW'(1);
            end
          end
          S_FIN_RD2: r_r <= r_r ^ PData;
          S_FIN_X:   r_l <= r_l ^ PData;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_blowfish128_round_ctrl.sv
// Bench for blowfish128_round_ctrl: random blocks and P-arrays checked against a
// textbook Blowfish loop model, plus backpressure, timeout, reset and abort cases.
module tb_blowfish128_round_ctrl;

  localparam int ROUNDS  = 16;
  localparam int PAW     = $clog2(ROUNDS + 2);
  localparam int LATENCY = 7 * ROUNDS + 3;

  logic           Clk = 1'b0;
  logic           RstN = 1'b0;
  logic           InValid = 1'b0;
  logic           Decrypt = 1'b0;
  logic [127:0]   DataIn = 128'h0;
  logic           Abort = 1'b0;
  logic           OutReady = 1'b0;
  logic           InReady, FEnable, FValid, OutValid, Busy, Err;
  logic [PAW-1:0] PAddr;
  logic [63:0]    PData = 64'h0;
  logic [63:0]    FX, FY;
  logic [127:0]   DataOut;

  logic [63:0]    pArr [0:ROUNDS+1];
  logic [3:0]     fCnt;
  logic           fNever = 1'b0;

  int passCount = 0;
  int checkCount = 0;
  int failCount = 0;

  int   enRises = 0;
  int   gapViol = 0;
  int   fxViol = 0;
  int   lowRun = 2;
  logic prevEn = 1'b0;
  logic [63:0] prevFx = 64'h0;

  blowfish128_round_ctrl #(.ROUNDS(ROUNDS), .PAW(PAW), .F_TIMEOUT(16)) dut (
    .Clk(Clk), .RstN(RstN), .InValid(InValid), .InReady(InReady), .Decrypt(Decrypt),
    .DataIn(DataIn), .Abort(Abort), .PAddr(PAddr), .PData(PData), .FEnable(FEnable),
    .FX(FX), .FY(FY), .FValid(FValid), .OutValid(OutValid), .OutReady(OutReady),
    .DataOut(DataOut), .Busy(Busy), .Err(Err)
  );

  always #5 Clk = ~Clk;

  function automatic logic [63:0] fModel(input logic [63:0] x);
    return {x[31:0] ^ 32'h9E37_79B9, x[63:32] + x[31:0]} ^ (x >> 13);
  endfunction

  // Registered P-array read port and a 4-stage F-function stub.
  always @(posedge Clk) PData <= pArr[PAddr];

  always @(posedge Clk or negedge RstN) begin
    if (!RstN)                fCnt <= 4'd0;
    else if (!FEnable)        fCnt <= 4'd0;
    else if (fCnt != 4'hF)    fCnt <= fCnt + 4'd1;
  end

  assign FValid = FEnable && !fNever && (fCnt == 4'd4);
  assign FY     = FValid ? fModel(FX) : 64'h0;

  // F-function handshake observer: rising edges, idle gaps, FX stability.
  always @(negedge Clk) begin
    if (FEnable && !prevEn) begin
      enRises++;
      if (lowRun < 2) gapViol++;
    end
    if (FEnable && prevEn && (FX !== prevFx)) fxViol++;
    lowRun = FEnable ? 0 : lowRun + 1;
    prevEn = FEnable;
    prevFx = FX;
  end

  function automatic logic [127:0] modelBlock(input logic [127:0] blk, input logic dec);
    logic [63:0] l, r, t;
    int k;
    l = blk[127:64];
    r = blk[63:0];
    for (int i = 0; i < ROUNDS; i++) begin
      k = dec ? (ROUNDS + 1 - i) : i;
      l = l ^ pArr[k];
      r = r ^ fModel(l);
      t = l; l = r; r = t;
    end
    t = l; l = r; r = t;
    r = r ^ pArr[dec ? 1 : ROUNDS];
    l = l ^ pArr[dec ? 0 : ROUNDS + 1];
    return {l, r};
  endfunction

  function automatic logic [127:0] randBlock();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Present one block at a negedge; returns at the negedge after the handshake edge.
  task automatic applyStimulus(input logic [127:0] blk, input logic dec);
    @(negedge Clk);
    checkOutput("inready_before_handshake", 128'(InReady), 128'(1));
    InValid = 1'b1;
    DataIn  = blk;
    Decrypt = dec;
    @(posedge Clk);
    @(negedge Clk);
    InValid = 1'b0;
    DataIn  = randBlock();
    Decrypt = ~dec;
  endtask

  task automatic waitOutput(output int edges, output logic seen);
    edges = 0;
    while (!OutValid && edges < 400) begin
      @(posedge Clk);
      edges++;
      @(negedge Clk);
    end
    seen = OutValid;
  endtask

  task automatic releaseOutput();
    OutReady = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    OutReady = 1'b0;
    checkOutput("inready_after_release", 128'(InReady), 128'(1));
    checkOutput("outvalid_after_release", 128'(OutValid), 128'(0));
  endtask

  task automatic runBlock(input string tag, input logic [127:0] blk, input logic dec,
                          output logic [127:0] res);
    int   edges;
    logic seen;
    applyStimulus(blk, dec);
    waitOutput(edges, seen);
    checkOutput({tag, "_outvalid"}, 128'(seen), 128'(1));
    checkOutput({tag, "_latency"}, 128'(edges), 128'(LATENCY));
    res = DataOut;
    checkOutput({tag, "_data"}, res, modelBlock(blk, dec));
    releaseOutput();
  endtask

  initial begin
    logic [127:0] x, y, z, exp;
    int   r0, g0, f0, n, enCycles;
    logic seen, errSeen, sawOut;

    for (int i = 0; i < ROUNDS + 2; i++) pArr[i] = {$urandom, $urandom};

    // Outputs while reset is held.
    repeat (3) @(negedge Clk);
    checkOutput("rst_inready",  128'(InReady),  128'(1));
    checkOutput("rst_fenable",  128'(FEnable),  128'(0));
    checkOutput("rst_fx",       128'(FX),       128'(0));
    checkOutput("rst_paddr",    128'(PAddr),    128'(0));
    checkOutput("rst_outvalid", 128'(OutValid), 128'(0));
    checkOutput("rst_dataout",  DataOut,        128'(0));
    checkOutput("rst_busy",     128'(Busy),     128'(0));
    checkOutput("rst_err",      128'(Err),      128'(0));
    RstN = 1'b1;

    // Nominal encrypt with F-function handshake observation.
    r0 = enRises; g0 = gapViol; f0 = fxViol;
    x = randBlock();
    runBlock("enc1", x, 1'b0, y);
    checkOutput("enc1_fenable_rises", 128'(enRises - r0), 128'(ROUNDS));
    checkOutput("enc1_fenable_gaps",  128'(gapViol - g0), 128'(0));
    checkOutput("enc1_fx_stable",     128'(fxViol - f0),  128'(0));

    // Round trip through decrypt.
    runBlock("dec1", y, 1'b1, z);
    checkOutput("roundtrip", z, x);

    // Backpressure: result held, new input ignored, no restart until released.
    x = randBlock();
    exp = modelBlock(x, 1'b0);
    applyStimulus(x, 1'b0);
    waitOutput(n, seen);
    checkOutput("bp_outvalid", 128'(seen), 128'(1));
    InValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      checkOutput("bp_data_stable",   DataOut,           exp);
      checkOutput("bp_valid_stable",  128'(OutValid),    128'(1));
      checkOutput("bp_inready_low",   128'(InReady),     128'(0));
    end
    InValid = 1'b0;
    releaseOutput();

    // F-function timeout.
    fNever = 1'b1;
    applyStimulus(randBlock(), 1'b0);
    n = 0; enCycles = 0; errSeen = 1'b0; sawOut = 1'b0;
    while (!errSeen && n < 200) begin
      @(posedge Clk);
      n++;
      @(negedge Clk);
      if (FEnable)  enCycles++;
      if (OutValid) sawOut = 1'b1;
      errSeen = Err;
    end
    checkOutput("to_err_seen",   128'(errSeen), 128'(1));
    checkOutput("to_frun_cycles",128'(enCycles),128'(16));
    checkOutput("to_no_output",  128'(sawOut),  128'(0));
    checkOutput("to_inready",    128'(InReady), 128'(1));
    fNever = 1'b0;
    @(negedge Clk);
    checkOutput("to_err_one_cycle", 128'(Err),  128'(0));
    checkOutput("to_busy_clear",    128'(Busy), 128'(0));
    runBlock("after_timeout", randBlock(), 1'b0, z);

    // Asynchronous reset in round 5.
    applyStimulus(randBlock(), 1'b1);
    repeat (5 * 7 + 3) begin
      @(posedge Clk);
      @(negedge Clk);
    end
    checkOutput("mid_fenable_high", 128'(FEnable), 128'(1));
    #2 RstN = 1'b0;
    #1;
    checkOutput("rstmid_fenable",  128'(FEnable),  128'(0));
    checkOutput("rstmid_outvalid", 128'(OutValid), 128'(0));
    checkOutput("rstmid_inready",  128'(InReady),  128'(1));
    @(negedge Clk);
    RstN = 1'b1;

    // Abort coincident with FValid.
    applyStimulus(randBlock(), 1'b0);
    repeat (10) begin
      @(posedge Clk);
      @(negedge Clk);
    end
    n = 0;
    while (!FValid && n < 50) begin
      @(posedge Clk);
      n++;
      @(negedge Clk);
    end
    checkOutput("abort_fvalid_found", 128'(FValid), 128'(1));
    Abort = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Abort = 1'b0;
    checkOutput("abort_busy",    128'(Busy),    128'(0));
    checkOutput("abort_inready", 128'(InReady), 128'(1));
    checkOutput("abort_fenable", 128'(FEnable), 128'(0));
    checkOutput("abort_err",     128'(Err),     128'(0));
    sawOut = 1'b0;
    repeat (5) begin
      @(posedge Clk);
      @(negedge Clk);
      if (OutValid || Err) sawOut = 1'b1;
    end
    checkOutput("abort_quiet", 128'(sawOut), 128'(0));
    runBlock("after_abort", randBlock(), 1'b0, z);

    // Abort while idle must not block an incoming handshake.
    x = randBlock();
    @(negedge Clk);
    Abort = 1'b1; InValid = 1'b1; DataIn = x; Decrypt = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Abort = 1'b0; InValid = 1'b0; DataIn = randBlock(); Decrypt = 1'b0;
    checkOutput("idle_abort_accepted", 128'(Busy), 128'(1));
    waitOutput(n, seen);
    checkOutput("idle_abort_latency", 128'(n), 128'(LATENCY));
    checkOutput("idle_abort_data", DataOut, modelBlock(x, 1'b1));
    releaseOutput();

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
